// File: rtl/mips_mem_arbiter.sv
// Shares the multi-cycle MIPS core's memory port with a loader/debug requester.
// Define MEM_ARB_STATS_EN to add the stall-cycle and loader-transfer counters.
module mips_mem_arbiter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_LDR_BURST = 4,
  parameter int CORE_SLOT     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wr_data,
  input  logic                  core_wr_en,
  output logic [DATA_WIDTH-1:0] core_rd_data,
  output logic                  core_stall,
  input  logic                  ldr_req,
  input  logic [ADDR_WIDTH-1:0] ldr_addr,
  input  logic                  ldr_wr_en,
  input  logic [DATA_WIDTH-1:0] ldr_wr_data,
  output logic                  ldr_gnt,
  output logic                  ldr_rd_valid,
  output logic [DATA_WIDTH-1:0] ldr_rd_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_wr_en,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]           stat_stall_cycles,
  output logic [31:0]           stat_ldr_xfers
`endif
);

  typedef enum logic {S_CORE, S_LDR} state_t;

  localparam logic [7:0] SLOT_MIN   = 8'(CORE_SLOT);
  localparam logic [7:0] BURST_LAST = 8'(MAX_LDR_BURST - 1);

  state_t     state;
  logic [7:0] burst_cnt;
  logic [7:0] slot_cnt;
  logic       in_ldr;

  assign in_ldr = (state == S_LDR);

  // The loader only ever sees a grant while it owns memory; core writes are masked then.
  assign ldr_gnt      = in_ldr && ldr_req;
  assign mem_addr     = in_ldr ? ldr_addr    : core_addr;
  assign mem_wr_data  = in_ldr ? ldr_wr_data : core_wr_data;
  assign mem_wr_en    = in_ldr ? (ldr_req && ldr_wr_en) : core_wr_en;
  assign core_rd_data = mem_rd_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_CORE;
      core_stall   <= 1'b0;
      ldr_rd_valid <= 1'b0;
      ldr_rd_data  <= '0;
      burst_cnt    <= '0;
      slot_cnt     <= '0;
    end else begin
      ldr_rd_valid <= 1'b0;
      case (state)
        S_CORE: begin
          if (slot_cnt < SLOT_MIN)
            slot_cnt <= slot_cnt + 8'd1;
          if (ldr_req && (slot_cnt >= SLOT_MIN)) begin
            state      <= S_LDR;
            core_stall <= 1'b1;
          end
        end
        S_LDR: begin
          if (ldr_req) begin
            if (!ldr_wr_en) begin
              ldr_rd_data  <= mem_rd_data;
              ldr_rd_valid <= 1'b1;
            end
            // The acceptance that fills the burst hands memory straight back to the core.
            if (burst_cnt == BURST_LAST) begin
              state      <= S_CORE;
              core_stall <= 1'b0;
              burst_cnt  <= '0;
              slot_cnt   <= '0;
            end else begin
              burst_cnt <= burst_cnt + 8'd1;
            end
          end else begin
            state      <= S_CORE;
            core_stall <= 1'b0;
            burst_cnt  <= '0;
            slot_cnt   <= '0;
          end
        end
        default: begin
          state      <= S_CORE;
          core_stall <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  // Both counters saturate rather than wrap so long runs never read back as small values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_stall_cycles <= '0;
      stat_ldr_xfers    <= '0;
    end else begin
      if (core_stall && (stat_stall_cycles != '1))
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      if (ldr_gnt && (stat_ldr_xfers != '1))
        stat_ldr_xfers <= stat_ldr_xfers + 32'd1;
    end
  end
`endif

endmodule
